fetch_controller: RTL and testbench



---
 rtl/fetch_controller_pkg.sv | 13 +
 rtl/fetch_ctrl_imem_mux.sv | 17 +
 rtl/fetch_ctrl_perf.sv | 34 +++
 rtl/fetch_controller.sv | 144 ++++++++++++++
 tb/tb_fetch_controller.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared types for the fetch controller: FSM state encoding and the sequential PC step.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    FetchRun    = 2'd0,
    FetchBrWait = 2'd1,
    FetchHalt   = 2'd2,
    FetchLoad   = 2'd3
  } fetch_ctrl_state_e;

  localparam int unsigned PcStep = 4;

endpackage

// File: rtl/fetch_ctrl_imem_mux.sv
// Instruction-memory port mux: the loader owns the port while the controller is in LOAD.
module fetch_ctrl_imem_mux #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] load_addr_i,
  input  logic            load_sel_i,
  output logic [XLEN-1:0] imem_addr_o,
  output logic            load_grant_o
);

  always_comb begin
    imem_addr_o  = load_sel_i ? load_addr_i : pc_i;
    load_grant_o = load_sel_i;
  end

endmodule

// File: rtl/fetch_ctrl_perf.sv
// Saturating stall/flush performance counters, instantiated only with FETCH_CTRL_PERF_EN.
module fetch_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o
);

  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_i && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (flush_i && (flush_q != '1)) flush_d = flush_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign perf_stall_cnt_o = stall_q;
  assign perf_flush_cnt_o = flush_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: PC register, fetch FSM and imem port arbitration with the loader.
// Optional perf counters are added when FETCH_CTRL_PERF_EN is defined.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     BR_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            data_hazard_i,
  input  logic            predict_miss_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            resolve_valid_i,
  input  logic            inst_is_branch_i,
  input  logic            predict_taken_i,
  input  logic            halt_req_i,
  input  logic            load_req_i,
  input  logic [XLEN-1:0] load_addr_i,
  input  logic            load_done_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] imem_addr_o,
  output logic            fetch_valid_o,
  output logic            fetch_hold_o,
  output logic            load_grant_o,
  output logic            halted_o,
  output logic            br_timeout_err_o,
`ifdef FETCH_CTRL_PERF_EN
  output logic [31:0]     perf_stall_cnt_o,
  output logic [31:0]     perf_flush_cnt_o,
`endif
  output logic [1:0]      state_o
);

  localparam int unsigned     CntW   = $clog2(BR_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(BR_TIMEOUT);

  fetch_ctrl_state_e state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              valid, hold, miss_accept;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = '0;
    err_d       = err_q;
    valid       = 1'b0;
    hold        = 1'b0;
    miss_accept = 1'b0;
    if (predict_miss_i && (state_q != FetchLoad)) begin
      miss_accept = 1'b1;
      pc_d        = redirect_pc_i;
      state_d     = FetchRun;
    end else begin
      unique case (state_q)
        FetchRun: begin
          if (data_hazard_i) begin
            hold = 1'b1;
          end else if (halt_req_i) begin
            state_d = FetchHalt;
          end else if (inst_is_branch_i && predict_taken_i) begin
            valid   = 1'b1;
            state_d = FetchBrWait;
          end else begin
            valid = 1'b1;
            pc_d  = pc_q + XLEN'(PcStep);
          end
        end
        FetchBrWait: begin
          if (resolve_valid_i) begin
            pc_d    = redirect_pc_i;
            state_d = FetchRun;
          end else begin
            // Counter saturates at the limit; the error stays sticky until reset.
            cnt_d = (cnt_q != CntMax) ? cnt_q + CntW'(1) : cnt_q;
            if (cnt_d == CntMax) err_d = 1'b1;
          end
        end
        FetchHalt: begin
          if (load_req_i) begin
            state_d = FetchLoad;
          end else if (!halt_req_i) begin
            state_d = FetchRun;
          end
        end
        FetchLoad: begin
          if (load_done_i) begin
            pc_d    = RESET_PC;
            state_d = FetchHalt;
          end else if (!load_req_i) begin
            state_d = FetchHalt;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FetchRun;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Combinational controls are forced to their reset values while rst is asserted.
  assign fetch_valid_o    = valid & ~rst;
  assign fetch_hold_o     = hold & ~rst;
  assign halted_o         = ((state_q == FetchHalt) || (state_q == FetchLoad)) & ~rst;
  assign pc_o             = pc_q;
  assign br_timeout_err_o = err_q;
  assign state_o          = state_q;

  fetch_ctrl_imem_mux #(
    .XLEN(XLEN)
  ) u_imem_mux (
    .pc_i        (pc_q),
    .load_addr_i (load_addr_i),
    .load_sel_i  ((state_q == FetchLoad) && !rst),
    .imem_addr_o (imem_addr_o),
    .load_grant_o(load_grant_o)
  );

`ifdef FETCH_CTRL_PERF_EN
  fetch_ctrl_perf u_perf (
    .clk             (clk),
    .rst             (rst),
    .stall_i         ((!fetch_valid_o || fetch_hold_o) && !halted_o && !rst),
    .flush_i         (miss_accept && !rst),
    .perf_stall_cnt_o(perf_stall_cnt_o),
    .perf_flush_cnt_o(perf_flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: expected outputs are queued when a cycle is driven
// and compared mid-cycle by a separate checker process.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_hazard, predict_miss, resolve_valid, inst_is_branch, predict_taken;
  logic        halt_req, load_req, load_done;
  logic [31:0] redirect_pc, load_addr;
  logic [31:0] pc, imem_addr;
  logic        fetch_valid, fetch_hold, load_grant, halted, br_timeout_err;
  logic [1:0]  state;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [1:0]  st;
    logic        valid, hold, grant, halted, err;
    logic [31:0] imem;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_controller #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .BR_TIMEOUT(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_hazard_i   (data_hazard),
    .predict_miss_i  (predict_miss),
    .redirect_pc_i   (redirect_pc),
    .resolve_valid_i (resolve_valid),
    .inst_is_branch_i(inst_is_branch),
    .predict_taken_i (predict_taken),
    .halt_req_i      (halt_req),
    .load_req_i      (load_req),
    .load_addr_i     (load_addr),
    .load_done_i     (load_done),
    .pc_o            (pc),
    .imem_addr_o     (imem_addr),
    .fetch_valid_o   (fetch_valid),
    .fetch_hold_o    (fetch_hold),
    .load_grant_o    (load_grant),
    .halted_o        (halted),
    .br_timeout_err_o(br_timeout_err),
`ifdef FETCH_CTRL_PERF_EN
    .perf_stall_cnt_o(perf_stall_cnt),
    .perf_flush_cnt_o(perf_flush_cnt),
`endif
    .state_o         (state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Start a new cycle at the falling edge with all stimulus deasserted.
  task automatic cyc();
    @(negedge clk);
    data_hazard    = 1'b0;
    predict_miss   = 1'b0;
    resolve_valid  = 1'b0;
    inst_is_branch = 1'b0;
    predict_taken  = 1'b0;
    halt_req       = 1'b0;
    load_req       = 1'b0;
    load_done      = 1'b0;
    redirect_pc    = 32'h0;
    load_addr      = 32'h0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] epc, input logic [1:0] est,
                            input logic ev, input logic eh, input logic eg, input logic ehl,
                            input logic ee, input logic [31:0] eimem);
    exp_t e;
    e.tag = tag; e.pc = epc; e.st = est; e.valid = ev; e.hold = eh;
    e.grant = eg; e.halted = ehl; e.err = ee; e.imem = eimem;
    sb.push_back(e);
  endtask

  // Checker: compares the oldest expectation shortly after each falling edge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({e.tag, ".pc"}, pc, e.pc);
      check_eq({e.tag, ".state"}, {30'd0, state}, {30'd0, e.st});
      check_eq({e.tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, e.valid});
      check_eq({e.tag, ".hold"}, {31'd0, fetch_hold}, {31'd0, e.hold});
      check_eq({e.tag, ".grant"}, {31'd0, load_grant}, {31'd0, e.grant});
      check_eq({e.tag, ".halted"}, {31'd0, halted}, {31'd0, e.halted});
      check_eq({e.tag, ".err"}, {31'd0, br_timeout_err}, {31'd0, e.err});
      check_eq({e.tag, ".imem"}, imem_addr, e.imem);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    //                 tag          pc            st v  h  g  hl e  imem
    cyc(); rst = 1'b1;
    expect_out("rst",       32'h00, 2'd0, 0, 0, 0, 0, 0, 32'h00);
    cyc(); rst = 1'b0;
    expect_out("run0",      32'h00, 2'd0, 1, 0, 0, 0, 0, 32'h00);
    cyc(); expect_out("run1", 32'h04, 2'd0, 1, 0, 0, 0, 0, 32'h04);
    cyc(); expect_out("run2", 32'h08, 2'd0, 1, 0, 0, 0, 0, 32'h08);
    cyc(); expect_out("run3", 32'h0C, 2'd0, 1, 0, 0, 0, 0, 32'h0C);
    cyc(); inst_is_branch = 1; predict_taken = 1;
    expect_out("br",        32'h10, 2'd0, 1, 0, 0, 0, 0, 32'h10);
    for (int i = 0; i < 3; i++) begin
      cyc(); expect_out($sformatf("bw%0d", i), 32'h10, 2'd1, 0, 0, 0, 0, 0, 32'h10);
    end
    cyc(); resolve_valid = 1; redirect_pc = 32'h40;
    expect_out("resolve",   32'h10, 2'd1, 0, 0, 0, 0, 0, 32'h10);
    cyc(); expect_out("after_res", 32'h40, 2'd0, 1, 0, 0, 0, 0, 32'h40);
    cyc(); data_hazard = 1; predict_miss = 1; redirect_pc = 32'h80;
    expect_out("miss_hz",   32'h44, 2'd0, 0, 0, 0, 0, 0, 32'h44);
    cyc(); data_hazard = 1;
    expect_out("hazard",    32'h80, 2'd0, 0, 1, 0, 0, 0, 32'h80);
    cyc(); halt_req = 1;
    expect_out("halt",      32'h80, 2'd0, 0, 0, 0, 0, 0, 32'h80);
    cyc(); halt_req = 1;
    expect_out("halted",    32'h80, 2'd2, 0, 0, 0, 1, 0, 32'h80);
    cyc(); halt_req = 1; load_req = 1; load_addr = 32'h200;
    expect_out("lreq",      32'h80, 2'd2, 0, 0, 0, 1, 0, 32'h80);
    cyc(); halt_req = 1; load_req = 1; load_addr = 32'h200;
    data_hazard = 1; predict_miss = 1; redirect_pc = 32'h300;
    expect_out("load",      32'h80, 2'd3, 0, 0, 1, 1, 0, 32'h200);
    cyc(); halt_req = 1; load_req = 1; load_addr = 32'h204; load_done = 1;
    expect_out("ldone",     32'h80, 2'd3, 0, 0, 1, 1, 0, 32'h204);
    cyc(); halt_req = 1;
    expect_out("after_ld",  32'h00, 2'd2, 0, 0, 0, 1, 0, 32'h00);
    cyc(); expect_out("unhalt", 32'h00, 2'd2, 0, 0, 0, 1, 0, 32'h00);
    cyc(); expect_out("run_again", 32'h00, 2'd0, 1, 0, 0, 0, 0, 32'h00);
    cyc(); inst_is_branch = 1; predict_taken = 1;
    expect_out("to_br",     32'h04, 2'd0, 1, 0, 0, 0, 0, 32'h04);
    for (int i = 0; i < 4; i++) begin
      cyc(); expect_out($sformatf("to%0d", i), 32'h04, 2'd1, 0, 0, 0, 0, 0, 32'h04);
    end
    cyc(); halt_req = 1;
    expect_out("to_set",    32'h04, 2'd1, 0, 0, 0, 0, 1, 32'h04);
    cyc(); predict_miss = 1; redirect_pc = 32'hFFFF_FFFC;
    expect_out("to_miss",   32'h04, 2'd1, 0, 0, 0, 0, 1, 32'h04);
    cyc(); expect_out("wrap", 32'hFFFF_FFFC, 2'd0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    cyc(); expect_out("wrapped", 32'h00, 2'd0, 1, 0, 0, 0, 1, 32'h00);
    cyc(); inst_is_branch = 1; predict_taken = 1;
    expect_out("br2",       32'h04, 2'd0, 1, 0, 0, 0, 1, 32'h04);
    cyc(); rst = 1'b1;
    expect_out("bw_rst",    32'h04, 2'd1, 0, 0, 0, 0, 1, 32'h04);
    cyc(); rst = 1'b0;
    expect_out("post_rst",  32'h00, 2'd0, 1, 0, 0, 0, 0, 32'h00);
    cyc(); predict_miss = 1; halt_req = 1; redirect_pc = 32'h100;
    expect_out("miss_halt", 32'h04, 2'd0, 0, 0, 0, 0, 0, 32'h04);
    cyc(); halt_req = 1;
    expect_out("halt_next", 32'h100, 2'd0, 0, 0, 0, 0, 0, 32'h100);
    cyc(); halt_req = 1;
    expect_out("halt_in",   32'h100, 2'd2, 0, 0, 0, 1, 0, 32'h100);
    repeat (3) @(posedge clk);
    check_eq("sb_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
